// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: produces hsync/vsync/activevideo and x/y pixel
// coordinates for a raster display, defaulting to 640x480@60 Hz.
// Ports:
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-high reset
//   ce           pixel enable; counters advance only on edges with ce=1
//   x_px, y_px   horizontal / vertical counters (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   hsync, vsync sync outputs, active level set by HS_POL / VS_POL
//   activevideo  high inside the visible region
//   line_start   one-clk pulse when x_px becomes 0
//   frame_start  one-clk pulse when (x_px,y_px) becomes (0,0)
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       hsync,
  output logic       vsync,
  output logic       activevideo,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CW       = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Counters are 10 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          av_q, av_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  // Extended copies so region bounds equal to 1024 still compare correctly.
  logic [CW:0] x_ext;
  logic [CW:0] y_ext;

  // Next-state counters and outputs decoded from them, so the registered
  // syncs always line up with the coordinates shown in the same cycle.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    x_ext = {1'b0, x_d};
    y_ext = {1'b0, y_d};

    hs_d = ((x_ext >= 11'(HS_START)) && (x_ext < 11'(HS_END))) ? HS_POL : ~HS_POL;
    vs_d = ((y_ext >= 11'(VS_START)) && (y_ext < 11'(VS_END))) ? VS_POL : ~VS_POL;
    av_d = (x_ext < 11'(H_ACTIVE)) && (y_ext < 11'(V_ACTIVE));

    // Pulses only fire on an advancing edge; otherwise they clear.
    ls_d = ce && (x_d == '0);
    fs_d = ce && (x_d == '0) && (y_d == '0);
  end

  // Reset parks the counters on the last pixel so the first ce edge shows (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q  <= H_LAST;
      y_q  <= V_LAST;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      av_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      av_q <= av_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign x_px        = x_q;
  assign y_px        = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign activevideo = av_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel-timing generator that sits directly upstream of the colour-pattern top level. It produces hsync, vsync, activevideo and the x_px/y_px pixel coordinates that the pattern logic compares against to drive the 6-bit RGB outputs. Timing is fully parameterised, defaulting to 640x480@60 Hz. A clock-enable input allows clk to run faster than the pixel rate.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
ce  input  1  pixel enable; counters advance only on clk edges with ce=1
x_px  output  10  horizontal counter, 0..H_TOTAL-1
y_px  output  10  vertical counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level per HS_POL
vsync  output  1  vertical sync, level per VS_POL
activevideo  output  1  high when x_px<H_ACTIVE and y_px<V_ACTIVE
line_start  output  1  one-clk pulse when x_px becomes 0
frame_start  output  1  one-clk pulse when (x_px,y_px) becomes (0,0)

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Legal range: H_TOTAL and V_TOTAL must be ≤1024. Elaboration fails otherwise.
- Reset values (asserted asynchronously, held while reset=1):
  - x_px = H_TOTAL-1, y_px = V_TOTAL-1.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - activevideo = 0, line_start = 0, frame_start = 0.
- First pixel after reset: the first ce=1 edge after reset release presents (0,0), with line_start=1 and frame_start=1.
- Counting (on a clk edge with ce=1):
  - x_px increments.
  - At H_TOTAL-1, x_px wraps to 0 and y_px increments.
  - y_px wraps from V_TOTAL-1 to 0 on that same edge.
- Hold: on a clk edge with ce=0, x_px, y_px, hsync, vsync and activevideo hold their values.
- Pulse width: line_start and frame_start are cleared on the next clk edge regardless of ce. Each pulse is exactly one clk cycle wide.
- Registered outputs: all outputs are registered. hsync, vsync, activevideo and the pulses are decoded from the next-state counters, so in every cycle they correspond to the x_px/y_px values shown in that same cycle. Zero relative skew.
- Sync regions:
  - hsync = HS_POL when H_ACTIVE+H_FP ≤ x_px < H_ACTIVE+H_FP+H_SYNC (default 656..751); else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP ≤ y_px < V_ACTIVE+V_FP+V_SYNC (default 490..491), for the whole line; else ~VS_POL.
- activevideo: purely combinational on the region, then registered. Blanking coordinates are still presented on x_px/y_px (not clamped).
- Reset mid-frame: outputs return to reset values immediately. Counting restarts cleanly with frame_start on the first ce edge after release. No partial pulse is emitted.
- Arithmetic: comparisons are unsigned 10-bit. No counter state outside the stated ranges is reachable.

Test Plan:
- Reset check: reset=1 with ce=1 → x_px=799, y_px=524, hsync=1, vsync=1, activevideo=0, pulses 0. Release reset → next edge x_px=0, y_px=0, frame_start=1 for 1 cycle.
- Line timing: ce=1 for 800 cycles → hsync=0 for exactly 96 cycles starting at x_px=656; activevideo high 640 cycles; line_start once per 800 cycles.
- Frame timing: ce=1 free-running → frame_start period 420000 cycles; vsync=0 for 1600 cycles starting at (0,490); 307200 activevideo cycles per frame.
- ce gating: ce toggling 1,0,1,0 → frame_start period 840000 cycles; outputs stable on ce=0 edges; pulses still exactly 1 clk wide.
- Reset mid-frame: assert reset asynchronously at (300,200) between clk edges → outputs reach reset values before the next edge. After release, frame_start on the first ce edge and a normal full frame follows.
- Polarity: HS_POL=1, VS_POL=1 → hsync high only at x_px 656..751, vsync high only at y_px 490..491; reset levels are 0.
